sudoku_check_sched: RTL and testbench
=====================================

// Module: sudoku_check_sched
// PURPOSE
//  Scan scheduler for the board-check datapath. On a check request from main_FSM (dp_check), it
//  sequences reads of all 81 board cells in 27 groups: 9 rows, then 9 columns, then 9 boxes.
//  Per group it tracks which digits have appeared, flags duplicates, out-of-range values and
//  empties, and returns a one-cycle verdict (done/valid/solved) that main_FSM uses for won.
// PARAMETERS
//  ADDR_W        7  board memory address width (cells 0..80, addr = 9*row + col)
//  DATA_W        4  cell value width (0 = empty, 1..9 = digit, 10..15 = illegal)
//  ABORT_ON_ERR  1  1: stop at the end of the first failing group; 0: always scan all 27 groups
// PORTS
//  clka       in   1       single clock, rising edge
//  restart    in   1       async reset, active-high
//  start      in   1       check request; sampled only in IDLE
//  cancel     in   1       sync abort; SCAN/DRAIN -> IDLE, no done
//  rd_en      out  1       board memory read strobe
//  rd_addr    out  ADDR_W  cell index being read
//  rd_data    in   DATA_W  cell value, valid the cycle after rd_en
//  busy       out  1       high in SCAN and DRAIN
//  done       out  1       one-cycle verdict pulse
//  valid      out  1       no conflict found (empties allowed); held until next start
//  solved     out  1       valid and no empty cell; held until next start
//  err_flag   out  1       conflict found (dup or illegal value); held until next start
//  err_group  out  5       first failing group: 0-8 row, 9-17 col, 18-26 box; 0 if none
// BEHAVIOUR
//  Reset: all outputs 0, rd_addr 0, FSM in IDLE, seen mask cleared. Async assert, sync release.
//  FSM: IDLE -start-> SCAN -last read issued-> DRAIN -last data checked-> DONE -> IDLE.
//   - DONE lasts exactly 1 cycle. done = 1 only in DONE.
//   - start while busy or in DONE: ignored.
//   - cancel beats the last-read and group-end transitions in the same cycle.
//   - restart beats everything, including in mid-scan.
//  Indexing: group type t = row, col or box; group g 0..8; element e 0..8.
//   - row: addr = 9g + e
//   - col: addr = 9e + g
//   - box: addr = 9*(3*(g/3) + e/3) + 3*(g%3) + e%3
//   - Keep counters for t, g and e. Compute addresses with adds and small lookups, not a
//     general divider.
//  Timing, with start high in cycle 0:
//   - rd_en is high, with consecutive addresses, in cycles 1..243. No bubbles.
//   - rd_data for a read is checked in the following cycle (cycles 2..244).
//   - A full scan ends with done high in cycle 245.
//   - Group k's last data arrives in cycle 9k+10.
//   - ABORT_ON_ERR=1: on a failing group k, rd_en drops after that group's reads. The reads
//     already in flight are discarded, and done fires in cycle 9k+11.
//  Check per group:
//   - Keep a 9-bit seen mask, cleared at the first element of each group.
//   - Value 0 sets the sticky empty flag.
//   - Value 10..15 is a conflict.
//   - Value v in 1..9 with seen[v-1] already set is a conflict. Otherwise set seen[v-1].
//   - A conflict is resolved at the group's last element.
//   - err_group latches the first failing group only.
//  Verdict, registered in DONE:
//   - valid = ~conflict
//   - solved = ~conflict & ~empty
//   - err_flag = conflict
//  On start, the verdict outputs and sticky flags are cleared in cycle 1.
//  A cancel leaves the verdict outputs at 0.
// TESTING
//  1. Full legal solved grid, start pulse -> rd_en cycles 1..243, done cycle 245, valid=1
//     solved=1 err_flag=0.
//  2. Solved grid with cell 40 = 0 -> done cycle 245, valid=1 solved=0 err_flag=0.
//  3. All cells 0 except cell0=5 and cell1=5, ABORT_ON_ERR=1 -> done cycle 11, err_group=0,
//     valid=0. Last rd_addr issued = 8.
//  4. All cells 0 except cell4=7 and cell13=7 -> err_group=13 (col 4), done cycle 128.
//     With ABORT_ON_ERR=0 -> done cycle 245, err_group still 13.
//  5. Grid with cell 80 = 12 -> err_flag=1, err_group=8 (row 8).
//  6. Robustness, each checked separately:
//     - start during SCAN -> ignored.
//     - cancel at cycle 50 -> IDLE in cycle 51, no done, busy=0.
//     - restart at cycle 100 -> all outputs 0 at once.
//     - A new start then gives a clean case-1 result.

Source files
------------

// File: rtl/sudoku_check_sched_if.sv
// Handshake and board-memory bus between main_FSM, the board RAM and the scan scheduler.
// The master side drives the request and supplies read data; the slave side is the scheduler.
interface sudoku_check_sched_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 4
);
   logic              start;
   logic              cancel;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;
   logic              valid;
   logic              solved;
   logic              err_flag;
   logic [4:0]        err_group;

   modport master (
      output start, cancel, rd_data,
      input  rd_en, rd_addr, busy, done, valid, solved, err_flag, err_group
   );

   modport slave (
      input  start, cancel, rd_data,
      output rd_en, rd_addr, busy, done, valid, solved, err_flag, err_group
   );
endinterface

// File: rtl/sudoku_check_sched.sv
// Board-check scan scheduler: reads all 81 cells as 9 rows, 9 columns and 9 boxes,
// checks each group for duplicates/illegal values/empties and reports a one-cycle verdict.
module sudoku_check_sched #(
   parameter int ADDR_W       = 7,
   parameter int DATA_W       = 4,
   parameter int ABORT_ON_ERR = 1
) (
   input logic                 clka,
   input logic                 restart,
   sudoku_check_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t      state, state_nxt;
   logic [1:0]  iss_t;
   logic [3:0]  iss_g, iss_e;
   logic        chk_valid;
   logic [3:0]  chk_e;
   logic [4:0]  chk_grp;
   logic [8:0]  seen;
   logic        grp_conf, conflict, empty;
   logic        valid_q, solved_q, err_flag_q;
   logic [4:0]  err_group_q;

   logic [6:0]  row_addr, col_addr, box_addr, cell_addr, box_base, box_off;
   logic [4:0]  grp_idx;
   logic [8:0]  seen_base, digit_hot, seen_nxt;
   logic        chk_act, illegal, dup, is_empty, grp_conf_nxt, group_fail;
   logic        abort_hit, last_issue, rd_en_int, conf_final, empty_final, start_ok;

   function automatic logic [6:0] mul9(input logic [3:0] x);
      return {x, 3'b000} + {3'b000, x};
   endfunction

   // Box addresses split into a per-box corner and a per-element offset, both tiny tables.
   always_comb begin
      box_base = 7'd0;
      box_off  = 7'd0;
      case (iss_g)
         4'd1: box_base = 7'd3;
         4'd2: box_base = 7'd6;
         4'd3: box_base = 7'd27;
         4'd4: box_base = 7'd30;
         4'd5: box_base = 7'd33;
         4'd6: box_base = 7'd54;
         4'd7: box_base = 7'd57;
         4'd8: box_base = 7'd60;
         default: box_base = 7'd0;
      endcase
      case (iss_e)
         4'd1: box_off = 7'd1;
         4'd2: box_off = 7'd2;
         4'd3: box_off = 7'd9;
         4'd4: box_off = 7'd10;
         4'd5: box_off = 7'd11;
         4'd6: box_off = 7'd18;
         4'd7: box_off = 7'd19;
         4'd8: box_off = 7'd20;
         default: box_off = 7'd0;
      endcase
      row_addr  = mul9(iss_g) + {3'b000, iss_e};
      col_addr  = mul9(iss_e) + {3'b000, iss_g};
      box_addr  = box_base + box_off;
      cell_addr = (iss_t == 2'd0) ? row_addr : (iss_t == 2'd1) ? col_addr : box_addr;
      grp_idx   = {iss_t, 3'b000} + {3'b000, iss_t} + {1'b0, iss_g};
   end

   // Per-element check of the returning data; a failing last element stops reads that same
   // cycle, which is why rd_en carries a combinational term from rd_data.
   always_comb begin
      chk_act   = chk_valid & ~bus.cancel;
      seen_base = (chk_e == 4'd0) ? 9'd0 : seen;
      for (int i = 0; i < 9; i++) digit_hot[i] = (bus.rd_data == DATA_W'(i + 1));
      illegal      = bus.rd_data > DATA_W'(9);
      is_empty     = bus.rd_data == '0;
      dup          = |(digit_hot & seen_base);
      grp_conf_nxt = ((chk_e == 4'd0) ? 1'b0 : grp_conf) | illegal | dup;
      seen_nxt     = seen_base | digit_hot;
      group_fail   = chk_act && (chk_e == 4'd8) && grp_conf_nxt;
      abort_hit    = (ABORT_ON_ERR != 0) && group_fail;
      last_issue   = (iss_t == 2'd2) && (iss_g == 4'd8) && (iss_e == 4'd8);
      rd_en_int    = (state == SCAN) && !abort_hit;
      conf_final   = conflict | group_fail;
      empty_final  = empty | (chk_act & is_empty);
      start_ok     = (state == IDLE) && bus.start;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.start) state_nxt = SCAN;
         SCAN:  begin
                   if (bus.cancel)     state_nxt = IDLE;
                   else if (abort_hit) state_nxt = DONE;
                   else if (last_issue) state_nxt = DRAIN;
                end
         DRAIN: begin
                   if (bus.cancel)                         state_nxt = IDLE;
                   else if (chk_valid && chk_e == 4'd8)    state_nxt = DONE;
                end
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clka or posedge restart) begin
      if (restart) state <= IDLE;
      else         state <= state_nxt;
   end

   // Element/group/type counters walk rows, then columns, then boxes, wrapping back to 0.
   always_ff @(posedge clka or posedge restart) begin
      if (restart) begin
         iss_t <= 2'd0;
         iss_g <= 4'd0;
         iss_e <= 4'd0;
      end else if (start_ok) begin
         iss_t <= 2'd0;
         iss_g <= 4'd0;
         iss_e <= 4'd0;
      end else if (rd_en_int) begin
         if (iss_e == 4'd8) begin
            iss_e <= 4'd0;
            if (iss_g == 4'd8) begin
               iss_g <= 4'd0;
               iss_t <= (iss_t == 2'd2) ? 2'd0 : iss_t + 2'd1;
            end else begin
               iss_g <= iss_g + 4'd1;
            end
         end else begin
            iss_e <= iss_e + 4'd1;
         end
      end
   end

   always_ff @(posedge clka or posedge restart) begin
      if (restart) begin
         chk_valid <= 1'b0;
         chk_e     <= 4'd0;
         chk_grp   <= 5'd0;
      end else begin
         chk_valid <= rd_en_int & ~bus.cancel;
         chk_e     <= iss_e;
         chk_grp   <= grp_idx;
      end
   end

   // Sticky flags and the verdict; the verdict is captured on the way into DONE.
   always_ff @(posedge clka or posedge restart) begin
      if (restart) begin
         seen <= 9'd0; grp_conf <= 1'b0; conflict <= 1'b0; empty <= 1'b0;
         valid_q <= 1'b0; solved_q <= 1'b0; err_flag_q <= 1'b0; err_group_q <= 5'd0;
      end else if (start_ok) begin
         seen <= 9'd0; grp_conf <= 1'b0; conflict <= 1'b0; empty <= 1'b0;
         valid_q <= 1'b0; solved_q <= 1'b0; err_flag_q <= 1'b0; err_group_q <= 5'd0;
      end else begin
         if (chk_act) begin
            seen     <= seen_nxt;
            grp_conf <= grp_conf_nxt;
            if (is_empty) empty <= 1'b1;
            if (group_fail) begin
               conflict <= 1'b1;
               if (!conflict) err_group_q <= chk_grp;
            end
         end
         if (state != DONE && state_nxt == DONE) begin
            valid_q    <= ~conf_final;
            solved_q   <= ~conf_final & ~empty_final;
            err_flag_q <= conf_final;
         end
      end
   end

   assign bus.rd_en     = rd_en_int;
   assign bus.rd_addr   = ADDR_W'(cell_addr);
   assign bus.busy      = (state == SCAN) || (state == DRAIN);
   assign bus.done      = (state == DONE);
   assign bus.valid     = valid_q;
   assign bus.solved    = solved_q;
   assign bus.err_flag  = err_flag_q;
   assign bus.err_group = err_group_q;

endmodule

// File: tb/tb_sudoku_check_sched.sv
// Bench for sudoku_check_sched: an aborting and a full-scan instance share one board image,
// driven by directed vector tables, random boards and hand-written robustness sequences.
module tb_sudoku_check_sched;

   logic clka = 1'b0;
   logic restart, start, cancel;
   logic [3:0] mem [0:80];

   sudoku_check_sched_if #(.ADDR_W(7), .DATA_W(4)) bus_a ();
   sudoku_check_sched_if #(.ADDR_W(7), .DATA_W(4)) bus_f ();

   assign bus_a.start  = start;
   assign bus_a.cancel = cancel;
   assign bus_f.start  = start;
   assign bus_f.cancel = cancel;

   sudoku_check_sched #(.ADDR_W(7), .DATA_W(4), .ABORT_ON_ERR(1)) dut_a (
      .clka(clka), .restart(restart), .bus(bus_a));
   sudoku_check_sched #(.ADDR_W(7), .DATA_W(4), .ABORT_ON_ERR(0)) dut_f (
      .clka(clka), .restart(restart), .bus(bus_f));

   always #5 clka = ~clka;

   // Registered board RAM: data appears the cycle after the read strobe.
   always @(posedge clka) if (bus_a.rd_en) bus_a.rd_data <= mem[bus_a.rd_addr];
   always @(posedge clka) if (bus_f.rd_en) bus_f.rd_data <= mem[bus_f.rd_addr];

   typedef struct {
      string name;
      int    grid;
      int    done_a;
      int    reads_a;
      int    last_a;
      int    valid;
      int    solved;
      int    err;
      int    grp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int exp_addr [0:242];
   int done_cyc [2], done_cnt [2], rd_cnt [2], last_addr [2], addr_err [2], gap_err [2];
   int busy_post [2];
   bit rst_zero;

   task automatic check_val(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int cell_of(input int k, input int e);
      int t = k / 9;
      int g = k % 9;
      if (t == 0) return 9 * g + e;
      if (t == 1) return 9 * e + g;
      return 9 * (3 * (g / 3) + e / 3) + 3 * (g % 3) + e % 3;
   endfunction

   function automatic int first_fail();
      for (int k = 0; k < 27; k++) begin
         int cnt [10];
         bit bad = 1'b0;
         for (int v = 0; v < 10; v++) cnt[v] = 0;
         for (int e = 0; e < 9; e++) begin
            int v = int'(mem[cell_of(k, e)]);
            if (v > 9) bad = 1'b1;
            else if (v != 0) begin
               if (cnt[v] != 0) bad = 1'b1;
               cnt[v]++;
            end
         end
         if (bad) return k;
      end
      return -1;
   endfunction

   function automatic bit any_empty();
      for (int i = 0; i < 81; i++) if (mem[i] == 4'd0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load_grid(input int kind);
      for (int i = 0; i < 81; i++) begin
         int r = i / 9;
         int c = i % 9;
         mem[i] = (kind == 2 || kind == 3) ? 4'd0 : 4'((r * 3 + r / 3 + c) % 9 + 1);
      end
      case (kind)
         1: mem[40] = 4'd0;
         2: begin mem[0] = 4'd5; mem[1] = 4'd5; end
         3: begin mem[4] = 4'd7; mem[13] = 4'd7; end
         4: mem[80] = 4'd12;
         default: ;
      endcase
   endtask

   task automatic sample_dut(input int d, input int c, input logic en, input logic [6:0] addr,
                             input logic dn, input logic bsy, input int cancel_at);
      if (en) begin
         rd_cnt[d]++;
         if (rd_cnt[d] != c) gap_err[d]++;
         if (rd_cnt[d] <= 243 && int'(addr) != exp_addr[rd_cnt[d] - 1]) addr_err[d]++;
         last_addr[d] = int'(addr);
      end
      if (dn) begin
         done_cnt[d]++;
         if (done_cyc[d] == 0) done_cyc[d] = c;
      end
      if (cancel_at >= 0 && c == cancel_at + 1) busy_post[d] = int'(bsy);
   endtask

   function automatic bit outputs_zero();
      return !bus_a.rd_en && bus_a.rd_addr == 0 && !bus_a.busy && !bus_a.done &&
             !bus_a.valid && !bus_a.solved && !bus_a.err_flag && bus_a.err_group == 0 &&
             !bus_f.rd_en && bus_f.rd_addr == 0 && !bus_f.busy && !bus_f.done &&
             !bus_f.valid && !bus_f.solved && !bus_f.err_flag && bus_f.err_group == 0;
   endfunction

   // Start pulse in cycle 0, then a fixed 270-cycle observation window.
   task automatic apply_stimulus(input int extra_start_at, input int cancel_at, input int restart_at);
      for (int d = 0; d < 2; d++) begin
         done_cyc[d] = 0; done_cnt[d] = 0; rd_cnt[d] = 0; last_addr[d] = -1;
         addr_err[d] = 0; gap_err[d] = 0; busy_post[d] = -1;
      end
      rst_zero = 1'b0;
      @(posedge clka); #1;
      start = 1'b1;
      for (int c = 1; c <= 270; c++) begin
         @(posedge clka); #1;
         start   = (c == extra_start_at);
         cancel  = (c == cancel_at);
         restart = (c == restart_at);
         if (c == restart_at) begin
            #1;
            rst_zero = outputs_zero();
         end
         @(negedge clka);
         sample_dut(0, c, bus_a.rd_en, bus_a.rd_addr, bus_a.done, bus_a.busy, cancel_at);
         sample_dut(1, c, bus_f.rd_en, bus_f.rd_addr, bus_f.done, bus_f.busy, cancel_at);
      end
      start = 1'b0; cancel = 1'b0; restart = 1'b0;
   endtask

   task automatic check_output(input vec_t v);
      string n = v.name;
      check_val({n, "/abort done_cycle"}, done_cyc[0], v.done_a);
      check_val({n, "/full done_cycle"}, done_cyc[1], 245);
      check_val({n, "/abort done_width"}, done_cnt[0], 1);
      check_val({n, "/full done_width"}, done_cnt[1], 1);
      check_val({n, "/abort reads"}, rd_cnt[0], v.reads_a);
      check_val({n, "/full reads"}, rd_cnt[1], 243);
      check_val({n, "/abort last_addr"}, last_addr[0], v.last_a);
      check_val({n, "/full last_addr"}, last_addr[1], 80);
      check_val({n, "/abort addr_seq_errs"}, addr_err[0], 0);
      check_val({n, "/full addr_seq_errs"}, addr_err[1], 0);
      check_val({n, "/abort rd_en_gaps"}, gap_err[0], 0);
      check_val({n, "/full rd_en_gaps"}, gap_err[1], 0);
      check_val({n, "/abort valid"}, int'(bus_a.valid), v.valid);
      check_val({n, "/full valid"}, int'(bus_f.valid), v.valid);
      check_val({n, "/abort solved"}, int'(bus_a.solved), v.solved);
      check_val({n, "/full solved"}, int'(bus_f.solved), v.solved);
      check_val({n, "/abort err_flag"}, int'(bus_a.err_flag), v.err);
      check_val({n, "/full err_flag"}, int'(bus_f.err_flag), v.err);
      check_val({n, "/abort err_group"}, int'(bus_a.err_group), v.grp);
      check_val({n, "/full err_group"}, int'(bus_f.err_group), v.grp);
   endtask

   vec_t table_v [5];

   initial begin
      vec_t rv;
      table_v[0] = '{"solved",     0, 245, 243, 80, 1, 1, 0, 0};
      table_v[1] = '{"empty40",    1, 245, 243, 80, 1, 0, 0, 0};
      table_v[2] = '{"dup_row0",   2,  11,   9,  8, 0, 0, 1, 0};
      table_v[3] = '{"dup_col4",   3, 128, 126, 76, 0, 0, 1, 13};
      table_v[4] = '{"illegal80",  4,  83,  81, 80, 0, 0, 1, 8};
      for (int i = 0; i < 243; i++) exp_addr[i] = cell_of(i / 9, i % 9);

      restart = 1'b1; start = 1'b0; cancel = 1'b0;
      load_grid(0);
      repeat (3) @(posedge clka);
      #1;
      check_val("reset outputs_zero_in_reset", int'(outputs_zero()), 1);
      restart = 1'b0;
      @(negedge clka);
      check_val("reset outputs_zero_after_release", int'(outputs_zero()), 1);

      for (int i = 0; i < 5; i++) begin
         load_grid(table_v[i].grid);
         apply_stimulus(-1, -1, -1);
         check_output(table_v[i]);
      end

      for (int r = 0; r < 8; r++) begin
         int p [9];
         int f, mode, a, b;
         for (int i = 0; i < 9; i++) p[i] = i + 1;
         for (int i = 8; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            int tmp = p[i];
            p[i] = p[j]; p[j] = tmp;
         end
         load_grid(0);
         for (int i = 0; i < 81; i++) mem[i] = 4'(p[int'(mem[i]) - 1]);
         mode = int'($urandom_range(0, 3));
         a = int'($urandom_range(0, 80));
         b = int'($urandom_range(0, 80));
         if (mode == 1) mem[a] = 4'd0;
         if (mode == 2) mem[a] = mem[b];
         if (mode == 3) mem[a] = 4'($urandom_range(10, 15));
         f = first_fail();
         rv.name   = $sformatf("random%0d", r);
         rv.grid   = 0;
         rv.done_a = (f >= 0) ? 9 * f + 11 : 245;
         rv.reads_a = (f >= 0) ? 9 * (f + 1) : 243;
         rv.last_a = (f >= 0) ? cell_of(f, 8) : 80;
         rv.valid  = (f >= 0) ? 0 : 1;
         rv.solved = (f >= 0) ? 0 : int'(!any_empty());
         rv.err    = (f >= 0) ? 1 : 0;
         rv.grp    = (f >= 0) ? f : 0;
         apply_stimulus(-1, -1, -1);
         check_output(rv);
      end

      load_grid(0);
      apply_stimulus(20, -1, -1);
      rv = table_v[0];
      rv.name = "start_in_scan";
      check_output(rv);

      apply_stimulus(-1, 50, -1);
      check_val("cancel/abort busy_cycle51", busy_post[0], 0);
      check_val("cancel/full busy_cycle51", busy_post[1], 0);
      check_val("cancel/abort done_count", done_cnt[0], 0);
      check_val("cancel/full done_count", done_cnt[1], 0);
      check_val("cancel/abort valid", int'(bus_a.valid), 0);
      check_val("cancel/full solved", int'(bus_f.solved), 0);

      apply_stimulus(-1, -1, 100);
      check_val("restart/outputs_zero_at_once", int'(rst_zero), 1);
      check_val("restart/abort done_count", done_cnt[0], 0);
      check_val("restart/full done_count", done_cnt[1], 0);
      check_val("restart/outputs_zero_at_end", int'(outputs_zero()), 1);

      apply_stimulus(-1, -1, -1);
      rv = table_v[0];
      rv.name = "after_restart";
      check_output(rv);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
